// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM result buffer.
// IDDMM_RES_PINGPONG_EN selects two storage banks instead of one.
package iddmm_pkg;

  localparam int K_DEF = 128;
  localparam int N_DEF = 32;

`ifdef IDDMM_RES_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FILL = 2'd2
  } fill_st_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_PREF = 2'd1,
    D_OUT  = 2'd2
  } drain_st_t;

endpackage

// File: rtl/mm_res_bank_ram.sv
// Simple dual-port result RAM, one write and one read port; read data registered (1 cycle).
// No backpressure; read register only updates on i_re so the output holds while stalled.
module mm_res_bank_ram #(
  parameter int W     = 128,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mm_iddmm_res_buf.sv
// IDDMM result buffer: captures an N-word subtract result, replays it on a valid/ready stream.
// First word valid 2 cycles after the bank fills; 1 word/cycle; IDDMM_RES_PINGPONG_EN adds a second bank.
module mm_iddmm_res_buf
  import iddmm_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mm_done,
  output logic         mm_ack,
  output logic         sub_task_req,
  input  logic [K-1:0] sub_res,
  input  logic         sub_res_val,
  input  logic         sub_task_end,
  output logic [K-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         err_len,
  output logic         err_ovf
);

  localparam int                RAM_AW = $clog2(NBANK * N);
  localparam logic [ADDR_W:0]   CNT_N  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(N - 1);

  fill_st_t          r_fst, w_fst_nxt;
  drain_st_t         r_dst, w_dst_nxt;
  logic [ADDR_W:0]   r_wcnt, w_wcnt_nxt;
  logic [ADDR_W-1:0] r_rcnt, w_rcnt_nxt, w_rd_word;
  logic [1:0]        r_full;
  logic              r_err_len, r_err_ovf;
  logic              w_wb, w_rb, w_wr_en, w_rd_en;
  logic              w_fill_ok, w_fill_bad, w_drain_done;
  logic [RAM_AW-1:0] w_waddr, w_raddr;

  // ---------------- fill side ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fst <= F_IDLE;
    else        r_fst <= w_fst_nxt;
  end

  always_comb begin
    w_fst_nxt    = r_fst;
    w_wcnt_nxt   = r_wcnt;
    mm_ack       = 1'b0;
    sub_task_req = 1'b0;
    w_wr_en      = 1'b0;
    w_fill_ok    = 1'b0;
    w_fill_bad   = 1'b0;
    case (r_fst)
      F_IDLE: if (mm_done && !r_full[w_wb]) w_fst_nxt = F_REQ;
      F_REQ: begin
        mm_ack       = 1'b1;
        sub_task_req = 1'b1;
        w_wcnt_nxt   = '0;
        w_fst_nxt    = F_FILL;
      end
      F_FILL: begin
        if (sub_res_val && (r_wcnt != CNT_N)) begin
          w_wr_en    = 1'b1;
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
        // The updated count includes a word arriving together with task_end.
        if (sub_task_end) begin
          w_fst_nxt = F_IDLE;
          if (w_wcnt_nxt == CNT_N) w_fill_ok  = 1'b1;
          else                     w_fill_bad = 1'b1;
        end
      end
      default: w_fst_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_err_len <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_wcnt <= w_wcnt_nxt;
      if (w_fill_bad)                      r_err_len <= 1'b1;
      if (sub_res_val && (r_fst != F_FILL)) r_err_ovf <= 1'b1;
    end
  end

  // ---------------- drain side ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dst <= D_IDLE;
    else        r_dst <= w_dst_nxt;
  end

  always_comb begin
    w_dst_nxt    = r_dst;
    w_rcnt_nxt   = r_rcnt;
    w_rd_en      = 1'b0;
    w_rd_word    = r_rcnt;
    w_drain_done = 1'b0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    case (r_dst)
      D_IDLE: if (r_full[w_rb]) begin
        w_rcnt_nxt = '0;
        w_dst_nxt  = D_PREF;
      end
      D_PREF: begin
        w_rd_en   = 1'b1;
        w_dst_nxt = D_OUT;
      end
      D_OUT: begin
        m_tvalid = 1'b1;
        m_tlast  = (r_rcnt == LAST_W);
        // Read the next word only on a handshake so the RAM output holds during stalls.
        if (m_tready) begin
          if (r_rcnt == LAST_W) begin
            w_drain_done = 1'b1;
            w_dst_nxt    = D_IDLE;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
            w_rd_word  = r_rcnt + 1'b1;
            w_rd_en    = 1'b1;
          end
        end
      end
      default: w_dst_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rcnt <= '0;
    else        r_rcnt <= w_rcnt_nxt;
  end

  // A set and a clear never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      if (w_fill_ok)    r_full[w_wb] <= 1'b1;
      if (w_drain_done) r_full[w_rb] <= 1'b0;
    end
  end

`ifdef IDDMM_RES_PINGPONG_EN
  logic r_wb, r_rb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb <= 1'b0;
      r_rb <= 1'b0;
    end else begin
      if (w_fill_ok)    r_wb <= ~r_wb;
      if (w_drain_done) r_rb <= ~r_rb;
    end
  end

  assign w_wb    = r_wb;
  assign w_rb    = r_rb;
  assign w_waddr = {r_wb, r_wcnt[ADDR_W-1:0]};
  assign w_raddr = {r_rb, w_rd_word};
`else
  assign w_wb    = 1'b0;
  assign w_rb    = 1'b0;
  assign w_waddr = r_wcnt[ADDR_W-1:0];
  assign w_raddr = w_rd_word;
`endif

  mm_res_bank_ram #(
    .W     (K),
    .DEPTH (NBANK * N),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (sub_res),
    .i_re    (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (m_tdata)
  );

  assign err_len = r_err_len;
  assign err_ovf = r_err_ovf;

endmodule

// File: tb/tb_mm_iddmm_res_buf.sv
// Scoreboard bench for mm_iddmm_res_buf: directed passes push expected words, a monitor checks the stream.
module tb_mm_iddmm_res_buf;
  import iddmm_pkg::*;

  localparam int K = 128;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mm_done = 1'b0;
  logic         mm_ack;
  logic         sub_task_req;
  logic [K-1:0] sub_res = '0;
  logic         sub_res_val = 1'b0;
  logic         sub_task_end = 1'b0;
  logic [K-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         err_len;
  logic         err_ovf;

  mm_iddmm_res_buf #(.K(K), .N(N), .ADDR_W($clog2(N))) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mm_done      (mm_done),
    .mm_ack       (mm_ack),
    .sub_task_req (sub_task_req),
    .sub_res      (sub_res),
    .sub_res_val  (sub_res_val),
    .sub_task_end (sub_task_end),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .err_len      (err_len),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [K:0] exp_q[$];
  int         rdy_mode = 0;
  int         cyc = 0, ack_cnt = 0, ack_cyc = 0, tlast_cyc = 0, first_cyc = 0, hs_run = 0;

  task automatic chk(input string name, input logic [K:0] act, input logic [K:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [K-1:0] wval(input logic [31:0] tag, input int i);
    return {tag, tag, tag, 32'(i)};
  endfunction

  // ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = never ready
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          m_tready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    logic         stalled;
    logic [K-1:0] held_d;
    logic         held_l;
    logic [K:0]   e;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled = 1'b0;
        hs_run  = 0;
      end else begin
        if (mm_ack) begin
          ack_cnt++;
          ack_cyc = cyc;
        end
        if (stalled) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", m_tdata, held_d);
          chk("hold_last", m_tlast, held_l);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: actual=%0h required=no word", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", m_tdata, e[K-1:0]);
            chk("sb_last", m_tlast, e[K]);
          end
          if (hs_run == 0) first_cyc = cyc;
          hs_run++;
          if (m_tlast) begin
            tlast_cyc = cyc;
            hs_run    = 0;
          end
        end
        stalled = m_tvalid && !m_tready;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Raise mm_done and wait up to max cycles for mm_ack; lat=-1 when none arrives.
  task automatic req_ack(input int max, output int lat);
    mm_done = 1'b1;
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mm_ack) begin
        lat = c;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      mm_done = 1'b0;
    end
  endtask

  task automatic feed(input logic [31:0] tag, input int n);
    for (int i = 0; i < n; i++) begin
      sub_res      = wval(tag, i);
      sub_res_val  = 1'b1;
      sub_task_end = (i == n - 1);
      if (n == N) exp_q.push_back({(i == N - 1), wval(tag, i)});
      @(posedge clk);
      #1;
    end
    sub_res_val  = 1'b0;
    sub_task_end = 1'b0;
    sub_res      = '0;
  endtask

  task automatic do_pass(input logic [31:0] tag, input int n, input string name);
    int lat;
    req_ack(20, lat);
    chk(name, lat, 1);
    if (lat > 0) feed(tag, n);
  endtask

  task automatic wait_drain(input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, ack_base;
    logic found;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_mm_ack", mm_ack, 0);
    chk("rst_sub_req", sub_task_req, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_ovf", err_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single result, consumer always ready
    ack_base = ack_cnt;
    do_pass(32'h0, N, "t1_ack_lat");
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_tvalid) begin
        lat = c;
        break;
      end
    end
    chk("t1_valid_lat", lat, 2);
    wait_drain(200);
    chk("t1_ack_cnt", ack_cnt - ack_base, 1);
    chk("t1_burst_len", tlast_cyc - first_cyc, N - 1);

    // backpressure 1,0,0,1
    rdy_mode = 1;
    do_pass(32'h1111_0001, N, "t2_ack_lat");
    wait_drain(400);
    rdy_mode = 0;

    // consumer stalled: every free bank is accepted, the next request waits for a drain
    rdy_mode = 2;
    @(posedge clk);
    #1;
    ack_base = ack_cnt;
    for (int p = 0; p < NBANK; p++) do_pass(32'h2222_0000 + p, N, "t3_ack_lat");
    req_ack(60, lat);
    chk("t3_blocked", lat < 0, 1);
    rdy_mode = 0;
    req_ack(200, lat);
    chk("t3_late_ack", lat > 0, 1);
    chk("t3_ack_after_tlast", ack_cyc - tlast_cyc, 2);
    feed(32'h2222_00FF, N);
    wait_drain(600);
    chk("t3_ack_cnt", ack_cnt - ack_base, NBANK + 1);

    // short pass is discarded, then a good pass streams
    do_pass(32'h3333_0000, N - 2, "t4_ack_lat");
    repeat (10) @(negedge clk);
    chk("t4_err_len", err_len, 1);
    chk("t4_no_valid", m_tvalid, 0);
    chk("t4_err_ovf", err_ovf, 0);
    do_pass(32'h3333_0001, N, "t4b_ack_lat");
    wait_drain(200);

    // stray word outside a pass
    sub_res     = wval(32'hDEAD_0000, 7);
    sub_res_val = 1'b1;
    @(posedge clk);
    #1;
    sub_res_val = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_no_valid", m_tvalid, 0);

    // reset in the middle of a drain
    do_pass(32'h4444_0000, N, "t5_ack_lat");
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && (m_tdata == wval(32'h4444_0000, 10))) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_word10_seen", found, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_tvalid", m_tvalid, 0);
    chk("t5_rst_tlast", m_tlast, 0);
    chk("t5_rst_tdata", m_tdata, 0);
    chk("t5_rst_mm_ack", mm_ack, 0);
    chk("t5_rst_err_len", err_len, 0);
    chk("t5_rst_err_ovf", err_ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_pass(32'h5555_0000, N, "t5b_ack_lat");
    wait_drain(200);
    chk("t5_err_len_after", err_len, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_res_buf.md
# mm_iddmm_res_buf

Result buffer directly downstream of the IDDMM final compare/subtract stage. It requests the subtract pass and captures the N-word result (K bits per word, low word first, no backpressure) into local storage. It then replays the result on a valid/ready stream with backpressure to the system. This decouples the next modular multiplication from a slow result consumer.

## Interface
Parameters:
- K, 128, word width in bits (power of two, ≤128).
- N, 32, words per result (power of two, ≤32).
- ADDR_W, $clog2(N), word address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mm_done  in  1  level; main IDDMM loop finished, result pending in RAM A.
- mm_ack  out  1  1-cycle pulse; pending result accepted, main loop may drop mm_done.
- sub_task_req  out  1  1-cycle pulse to the subtract stage.
- sub_res  in  K  result word from the subtract stage.
- sub_res_val  in  1  sub_res valid. No backpressure.
- sub_task_end  in  1  subtract pass done; may coincide with the final sub_res_val.
- m_tdata  out  K  output word, low word first.
- m_tvalid  out  1  output valid.
- m_tready  in  1  consumer ready.
- m_tlast  out  1  high on word N-1.
- err_len  out  1  sticky; a pass ended with a word count ≠ N.
- err_ovf  out  1  sticky; sub_res_val arrived while not in F_FILL.

## Operation
- Storage is bank-organised. The fill side writes bank wb, a 1-bit pointer. The drain side reads bank rb. Each bank has a full flag.
- Fill FSM:
  - F_IDLE: when mm_done=1 and full[wb]=0, go to F_REQ.
  - F_REQ: pulse sub_task_req and mm_ack in the same cycle, clear wcnt, go to F_FILL.
  - F_FILL: on each sub_res_val, write sub_res to bank[wb][wcnt] and increment wcnt. wcnt is ADDR_W+1 bits and saturates at N.
  - On sub_task_end (counting a coincident final word): if the count equals N, set full[wb], toggle wb (ping-pong only), and return to F_IDLE. Otherwise set err_len, leave full[wb] clear (bank discarded), and return to F_IDLE.
- Drain FSM:
  - D_IDLE: when full[rb]=1, set rcnt=0 and go to D_PREF.
  - D_PREF: one-cycle RAM read latency, then go to D_OUT.
  - D_OUT: m_tvalid=1. On m_tvalid&&m_tready, advance rcnt. The next word is prefetched so that back-to-back handshakes give 1 word/cycle.
  - After the handshake on word N-1, clear full[rb], toggle rb (ping-pong only), and go to D_IDLE.
- Output stability: m_tdata and m_tlast hold stable while m_tvalid && !m_tready. m_tvalid never drops before its handshake.
- Any sub_res_val outside F_FILL is dropped and sets err_ovf.
- Error flags are cleared only by reset.
- No arithmetic beyond counters. Data passes through bit-exact.

## Timing
- Reset: all outputs 0. FSMs go to F_IDLE/D_IDLE, full flags 0, wb=rb=0, counters 0.
- Reset mid-operation discards all buffered data. No partial stream continues after reset release.
- mm_done sampled with a free bank → mm_ack and sub_task_req high in the next cycle (F_REQ).
- Final sub_res_val of a bank → full set at the next edge → m_tvalid high 2 cycles after that (D_IDLE, D_PREF, D_OUT), when the drain is idle.
- Steady-state throughput with m_tready=1: N words in N cycles, then a 2-cycle gap before the next bank.
- Drain clearing full[x] in the same cycle that F_IDLE evaluates full[x]: F_IDLE sees the old value, so the fill starts 1 cycle later. No bypass.
- Fill setting full[x] in the same cycle D_IDLE evaluates it: same rule, the drain starts 1 cycle later.

## Configuration
- IDDMM_RES_PINGPONG_EN defined: two banks (2·N·K bits). Filling of the next result overlaps draining of the previous one.
- Not defined: one bank. wb and rb are tied to 0. F_IDLE waits until the drain has released the bank before issuing mm_ack. Other behaviour and latencies are unchanged.

## Structure
- Shared package iddmm_pkg holds:
  - K/N default constants.
  - The fill and drain state enums.
  - A localparam for the bank count, derived from IDDMM_RES_PINGPONG_EN.
- Sub-module mm_res_bank_ram: simple dual-port RAM, one write port and one read port, registered read with 1-cycle latency, depth banks·N, address {bank, word}.

## Test plan
- Single result, K=128, N=32: mm_done=1, sub returns words 0..31 with value i, task_end on word 31, m_tready=1 → m_tdata=0..31 on consecutive cycles, m_tlast on 31, mm_ack pulses once.
- Backpressure: m_tready toggles 1,0,0,1 repeating → each word held stable while stalled, order 0..31 preserved, no duplicates.
- Ping-pong (macro on), m_tready=0 during two passes → both passes are accepted. A third mm_done gets no mm_ack until the first bank fully drains.
- Macro off, same stimulus → the second mm_ack waits until the first bank's m_tlast handshake.
- Short pass: task_end after 30 words → err_len=1, no m_tvalid, next good pass streams normally.
- Assert rst_n mid-drain at word 10 → all outputs 0 at once. After release, a new pass streams from word 0.
